// File: rtl/rvfi_commit_serializer_if.sv
// Stand-in riscv/rvfi_pkg packages plus the output record stream interface
// shared by rvfi_commit_serializer and its consumer.
package riscv;
  localparam int unsigned XLEN = 32;
endpackage

package rvfi_pkg;
  typedef struct packed {
    logic                     valid;
    logic [63:0]              order;
    logic [31:0]              insn;
    logic                     trap;
    logic [riscv::XLEN-1:0]   pc_rdata;
    logic [riscv::XLEN-1:0]   mem_addr;
    logic [riscv::XLEN/8-1:0] mem_wmask;
    logic [riscv::XLEN-1:0]   mem_wdata;
  } rvfi_instr_t;
endpackage

interface rvfi_commit_serializer_if;
  logic                  out_valid_o;
  logic                  out_ready_i;
  rvfi_pkg::rvfi_instr_t out_o;

  modport master (output out_valid_o, output out_o, input out_ready_i);
  modport slave  (input out_valid_o, input out_o, output out_ready_i);
endinterface

// File: rtl/rvfi_commit_serializer.sv
// Serialises up to NR_COMMIT_PORTS RVFI commits per cycle into a single-record
// stream and stops on a tohost write. Optional macro: RVFI_SER_TRAP_RECORD_EN.
module rvfi_commit_serializer #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  input  logic [riscv::XLEN-1:0]                      tohost_addr_i,
  rvfi_commit_serializer_if.master                    out_if,
  output logic [$clog2(DEPTH):0]                      count_o,
  output logic                                        overflow_o,
  output logic                                        halt_o,
  output logic [riscv::XLEN-1:0]                      exit_code_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef enum logic [1:0] {RUN, ARMED, HALTED} state_e;

  state_e                 r_state, w_state_nxt;
  rvfi_pkg::rvfi_instr_t  r_mem [DEPTH];
  ptr_t                   r_wptr, r_rptr;
  cnt_t                   r_count;
  logic                   r_overflow;
  logic [riscv::XLEN-1:0] r_exit_code;

  logic                       w_pop;
  cnt_t                       w_free;
  cnt_t                       w_n_acc;
  logic [NR_COMMIT_PORTS-1:0] w_req;
  logic [NR_COMMIT_PORTS-1:0] w_acc;
  ptr_t                       w_waddr [NR_COMMIT_PORTS];
  logic                       w_drop;
  logic                       w_arm;
  logic [riscv::XLEN-1:0]     w_arm_data;

  assign w_pop  = (r_count != '0) && out_if.out_ready_i;
  assign w_free = cnt_t'(DEPTH) - r_count + cnt_t'(w_pop);

  // Accept requests in port order while space lasts; the first tohost hit
  // ends the cycle, so later ports are discarded rather than counted as drops.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_req      = '0;
    w_acc      = '0;
    w_n_acc    = '0;
    w_drop     = 1'b0;
    w_arm      = 1'b0;
    w_arm_data = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_waddr[i] = '0;
`ifdef RVFI_SER_TRAP_RECORD_EN
      w_req[i] = rvfi_i[i].valid | rvfi_i[i].trap;
`else
      w_req[i] = rvfi_i[i].valid;
`endif
    end
    if (r_state == RUN) begin
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (!w_arm && w_req[i]) begin
          if (w_n_acc < w_free) begin
            w_acc[i]   = 1'b1;
            w_waddr[i] = r_wptr + w_n_acc[AW-1:0];
            w_n_acc    = w_n_acc + 1'b1;
            if ((tohost_addr_i != '0) && (rvfi_i[i].mem_addr == tohost_addr_i) &&
                (rvfi_i[i].mem_wmask != '0) && (rvfi_i[i].mem_wdata != '0)) begin
              w_arm      = 1'b1;
              w_arm_data = rvfi_i[i].mem_wdata;
            end
          end else begin
            w_drop = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_arm) w_state_nxt = ARMED;
      ARMED:   if (r_count == '0) w_state_nxt = HALTED;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_exit_code <= '0;
    end else begin
      r_wptr     <= r_wptr + w_n_acc[AW-1:0];
      r_rptr     <= r_rptr + ptr_t'(w_pop);
      r_count    <= r_count + w_n_acc - cnt_t'(w_pop);
      r_overflow <= r_overflow | w_drop;
      if (w_arm) r_exit_code <= w_arm_data;
    end
  end

  // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (w_acc[i]) r_mem[w_waddr[i]] <= rvfi_i[i];
    end
  end

  assign out_if.out_valid_o = (r_count != '0);
  assign out_if.out_o       = r_mem[r_rptr];
  assign count_o            = r_count;
  assign overflow_o         = r_overflow;
  assign halt_o             = (r_state == HALTED);
  assign exit_code_o        = r_exit_code;

endmodule
